// File: rtl/ip_dispatch_pkg.sv
// Shared types and constants for the IP protocol dispatcher.
// State enum, map-entry layout, well-known protocol numbers.
package ip_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD,
    DROP
  } state_e;

  localparam logic [7:0] PROTO_ICMP = 8'h01;
  localparam logic [7:0] PROTO_TCP  = 8'h06;
  localparam logic [7:0] PROTO_UDP  = 8'h11;

  localparam int CNT_W = 32;

  typedef struct packed {
    logic       en;
    logic [7:0] proto;
    logic [2:0] port;
  } map_entry_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic             inc
  );
    return (inc && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

endpackage

// File: rtl/ip_proto_dispatch_if.sv
// Header + payload bundle between the IP source and the protocol ports.
// slave is the dispatcher side, master is the surrounding fabric.
interface ip_proto_dispatch_if #(
  parameter int NUM_PORTS = 4
);
  logic                 s_hdr_valid;
  logic                 s_hdr_ready;
  logic [7:0]           s_ip_protocol;
  logic [31:0]          s_ip_source_ip;
  logic [15:0]          s_ip_length;
  logic [7:0]           s_tdata;
  logic                 s_tvalid;
  logic                 s_tready;
  logic                 s_tlast;
  logic                 s_tuser;

  logic [NUM_PORTS-1:0] m_hdr_valid;
  logic [NUM_PORTS-1:0] m_hdr_ready;
  logic [7:0]           m_ip_protocol;
  logic [31:0]          m_ip_source_ip;
  logic [15:0]          m_ip_length;
  logic [7:0]           m_tdata;
  logic                 m_tlast;
  logic                 m_tuser;
  logic [NUM_PORTS-1:0] m_tvalid;
  logic [NUM_PORTS-1:0] m_tready;

  modport slave (
    input  s_hdr_valid, s_ip_protocol, s_ip_source_ip, s_ip_length,
    input  s_tdata, s_tvalid, s_tlast, s_tuser,
    output s_hdr_ready, s_tready,
    output m_hdr_valid, m_ip_protocol, m_ip_source_ip, m_ip_length,
    output m_tdata, m_tlast, m_tuser, m_tvalid,
    input  m_hdr_ready, m_tready
  );

  modport master (
    output s_hdr_valid, s_ip_protocol, s_ip_source_ip, s_ip_length,
    output s_tdata, s_tvalid, s_tlast, s_tuser,
    input  s_hdr_ready, s_tready,
    input  m_hdr_valid, m_ip_protocol, m_ip_source_ip, m_ip_length,
    input  m_tdata, m_tlast, m_tuser, m_tvalid,
    output m_hdr_ready, m_tready
  );
endinterface

// File: rtl/ip_dispatch_stats.sv
// Saturating per-port packet/error counters plus a drop counter.
// Counters load their next value every cycle; clear beats increment.
module ip_dispatch_stats
  import ip_dispatch_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int SW        = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clr,
  input  logic [NUM_PORTS-1:0] i_pkt_inc,
  input  logic [NUM_PORTS-1:0] i_err_inc,
  input  logic                 i_drop_inc,
  input  logic [SW-1:0]        i_sel,
  output logic [CNT_W-1:0]     o_pkt,
  output logic [CNT_W-1:0]     o_err
);

  logic [NUM_PORTS-1:0][CNT_W-1:0] r_pkt, r_err;
  logic [NUM_PORTS-1:0][CNT_W-1:0] w_pkt_nxt, w_err_nxt;
  logic [CNT_W-1:0]                r_drop, w_drop_nxt;

  always_comb begin
    w_drop_nxt = i_clr ? '0 : sat_inc(r_drop, i_drop_inc);
    w_pkt_nxt  = '0;
    w_err_nxt  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_pkt_nxt[i] = i_clr ? '0 : sat_inc(r_pkt[i], i_pkt_inc[i]);
      w_err_nxt[i] = i_clr ? '0 : sat_inc(r_err[i], i_err_inc[i]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pkt  <= '0;
      r_err  <= '0;
      r_drop <= '0;
    end else begin
      r_pkt  <= w_pkt_nxt;
      r_err  <= w_err_nxt;
      r_drop <= w_drop_nxt;
    end
  end

  always_comb begin
    o_pkt = '0;
    o_err = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (int'(i_sel) == i) begin
        o_pkt = r_pkt[i];
        o_err = r_err[i];
      end
    end
    if (int'(i_sel) == NUM_PORTS) o_pkt = r_drop;
  end

endmodule

// File: rtl/ip_proto_dispatch.sv
// Routes each IP packet to the output port mapped to its protocol.
// Unmapped protocols are consumed and counted as drops.
module ip_proto_dispatch
  import ip_dispatch_pkg::*;
#(
  parameter  int NUM_PORTS   = 4,
  parameter  int MAP_ENTRIES = 4,
  parameter  int DATA_WIDTH  = 8,
  localparam int IW          = idx_w(MAP_ENTRIES),
  localparam int PW          = idx_w(NUM_PORTS),
  localparam int SW          = idx_w(NUM_PORTS + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  ip_proto_dispatch_if.slave      bus,
  input  logic                    cfg_we,
  input  logic [IW-1:0]           cfg_idx,
  input  logic [7:0]              cfg_proto,
  input  logic [PW-1:0]           cfg_port,
  input  logic                    cfg_en,
  input  logic [SW-1:0]           cnt_sel,
  input  logic                    cnt_clr,
  output logic [CNT_W-1:0]        cnt_pkt,
  output logic [CNT_W-1:0]        cnt_err
);

  if (DATA_WIDTH != 8) begin : g_dw_chk
    $error("ip_proto_dispatch: DATA_WIDTH must be 8");
  end

  state_e               r_state, w_state_nxt;
  map_entry_t           r_map [MAP_ENTRIES];
  logic [2:0]           r_port;
  logic [7:0]           r_proto;
  logic [31:0]          r_src;
  logic [15:0]          r_len;
  logic                 w_hit;
  logic [2:0]           w_port;
  logic                 w_hdr_acc;
  logic                 w_beat;
  logic [NUM_PORTS-1:0] w_oh;
  logic [NUM_PORTS-1:0] w_pkt_inc;

  // Descending scan so the lowest matching index has the last word.
  always_comb begin
    w_hit  = 1'b0;
    w_port = '0;
    for (int i = MAP_ENTRIES - 1; i >= 0; i--) begin
      if (r_map[i].en && r_map[i].proto == bus.s_ip_protocol &&
          int'(r_map[i].port) < NUM_PORTS) begin
        w_hit  = 1'b1;
        w_port = r_map[i].port;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < MAP_ENTRIES; i++) r_map[i] <= '0;
    end else if (cfg_we && int'(cfg_idx) < MAP_ENTRIES) begin
      r_map[cfg_idx] <= '{en: cfg_en, proto: cfg_proto, port: 3'(cfg_port)};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_port  <= '0;
      r_proto <= '0;
      r_src   <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hdr_acc) begin
        r_port  <= w_port;
        r_proto <= bus.s_ip_protocol;
        r_src   <= bus.s_ip_source_ip;
        r_len   <= bus.s_ip_length;
      end
    end
  end

  assign w_oh      = NUM_PORTS'(1) << r_port;
  assign w_hdr_acc = bus.s_hdr_valid && bus.s_hdr_ready;
  assign w_beat    = bus.s_tvalid && bus.s_tready;

  always_comb begin
    w_state_nxt     = r_state;
    bus.s_hdr_ready = 1'b0;
    bus.s_tready    = 1'b0;
    bus.m_hdr_valid = '0;
    bus.m_tvalid    = '0;
    unique case (r_state)
      IDLE: begin
        bus.s_hdr_ready = 1'b1;
        if (bus.s_hdr_valid) w_state_nxt = w_hit ? HDR : DROP;
      end
      HDR: begin
        bus.m_hdr_valid = w_oh;
        if (|(bus.m_hdr_ready & w_oh)) w_state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        bus.m_tvalid = w_oh & {NUM_PORTS{bus.s_tvalid}};
        bus.s_tready = |(bus.m_tready & w_oh);
        if (bus.s_tvalid && bus.s_tready && bus.s_tlast) w_state_nxt = IDLE;
      end
      DROP: begin
        bus.s_tready = 1'b1;
        if (bus.s_tvalid && bus.s_tlast) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.m_ip_protocol  = r_proto;
  assign bus.m_ip_source_ip = r_src;
  assign bus.m_ip_length    = r_len;
  assign bus.m_tdata        = bus.s_tdata;
  assign bus.m_tlast        = bus.s_tlast;
  assign bus.m_tuser        = bus.s_tuser;

  assign w_pkt_inc = (r_state == PAYLOAD && w_beat && bus.s_tlast) ?
                     w_oh : '0;

  ip_dispatch_stats #(
    .NUM_PORTS (NUM_PORTS),
    .SW        (SW)
  ) u_stats (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (cnt_clr),
    .i_pkt_inc  (w_pkt_inc),
    .i_err_inc  (w_pkt_inc & {NUM_PORTS{bus.s_tuser}}),
    .i_drop_inc (w_hdr_acc && !w_hit),
    .i_sel      (cnt_sel),
    .o_pkt      (cnt_pkt),
    .o_err      (cnt_err)
  );

endmodule

// File: doc/ip_proto_dispatch.md
IP_PROTO_DISPATCH -- requirements
Module: ip_proto_dispatch

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of protocol output ports (2..8).
REQ-002 SHALL have parameter MAP_ENTRIES, default 4, number of programmable protocol-map entries (1..16).
REQ-003 SHALL have parameter DATA_WIDTH, default 8, payload width; only 8 is supported, elaboration fails otherwise.
REQ-004 SHALL have port i_clk, in, 1, sole clock.
REQ-005 SHALL have port i_rst_n, in, 1, asynchronous active-low reset.
REQ-006 SHALL have port s_hdr_valid/s_hdr_ready, in/out, 1/1, input IP header handshake.
REQ-007 SHALL have port s_ip_protocol, in, 8; s_ip_source_ip, in, 32; s_ip_length, in, 16; latched header fields.
REQ-008 SHALL have port s_tdata/s_tvalid/s_tready/s_tlast/s_tuser, in/in/out/in/in, 8/1/1/1/1, input payload.
REQ-009 SHALL have port m_hdr_valid/m_hdr_ready, out/in, NUM_PORTS each, one-hot header handshake per port.
REQ-010 SHALL have port m_ip_protocol, m_ip_source_ip, m_ip_length, out, 8/32/16, broadcast latched header.
REQ-011 SHALL have port m_tdata/m_tlast/m_tuser, out, 8/1/1, broadcast payload; m_tvalid/m_tready, out/in, NUM_PORTS each.
REQ-012 SHALL have port cfg_we, in, 1; cfg_idx, in, clog2(MAP_ENTRIES); cfg_proto, in, 8; cfg_port, in, clog2(NUM_PORTS); cfg_en, in, 1; map-entry write.
REQ-013 SHALL have port cnt_sel, in, clog2(NUM_PORTS+1); cnt_pkt, out, 32; cnt_err, out, 32; cnt_clr, in, 1; statistics readout (sel==NUM_PORTS selects drop counter on cnt_pkt).

Function
REQ-014 SHALL implement FSM states IDLE, HDR, PAYLOAD, DROP.
REQ-015 IDLE: s_hdr_ready=1; on s_hdr_valid latch header fields and lookup result, go to HDR if a match exists, else DROP.
REQ-016 Lookup SHALL select the lowest-index enabled entry with cfg_proto==s_ip_protocol; no match = drop.
REQ-017 HDR: assert m_hdr_valid[port] only; on m_hdr_ready[port] go to PAYLOAD next cycle.
REQ-018 PAYLOAD: m_tvalid[port]=s_tvalid, s_tready=m_tready[port], combinational pass-through, zero added latency; on beat with s_tlast go to IDLE.
REQ-019 DROP: s_tready=1, all m_tvalid=0; on beat with s_tlast go to IDLE.
REQ-020 s_hdr_ready SHALL be 0 outside IDLE; s_tready SHALL be 0 in IDLE and HDR.
REQ-021 A cfg_we in any state SHALL update the entry next cycle and affect only headers accepted afterwards; a cfg_we in the same cycle as header acceptance is not seen by that lookup.
REQ-022 Per-port packet counter SHALL increment on the s_tlast beat in PAYLOAD; per-port error counter additionally when s_tuser=1 on that beat.
REQ-023 Drop counter SHALL increment on header acceptance leading to DROP.
REQ-024 Counters SHALL saturate at 32'hFFFFFFFF; cnt_clr zeroes all counters and wins over a simultaneous increment.
REQ-025 cnt_pkt/cnt_err SHALL be combinational reads of the selected counter; out-of-range cnt_sel returns 0.
REQ-026 Zero-length payload (s_tlast on first beat) SHALL be handled identically to longer packets.

Reset
REQ-027 On i_rst_n low: FSM=IDLE, all map entries disabled (all traffic dropped), counters 0, m_hdr_valid=0, m_tvalid=0, latched header 0.
REQ-028 Reset asserted mid-packet SHALL abort it; remaining payload after reset release is treated as a new header wait (no resync).

Structure
REQ-029 Shared package ip_dispatch_pkg SHALL hold the FSM state enum, protocol constants (ICMP 8'h01, TCP 8'h06, UDP 8'h11) and map-entry struct {en, proto, port}.
REQ-030 Sub-module ip_dispatch_stats SHALL contain the saturating counter bank; lookup and FSM stay in the top.

Verification
REQ-031 Map entry0={en,8'h06,port0}, entry1={en,8'h11,port1}; send TCP 10-byte packet -> m_hdr_valid[0] only, 10 beats on port0, cnt_pkt[0]=1.
REQ-032 Send protocol 8'h2F with no match -> no m_hdr_valid, s_tready=1 for all beats, drop counter=1.
REQ-033 Entries 0 and 2 both match 8'h01 to ports 2 and 3 -> packet goes to port 2.
REQ-034 Hold m_tready[1]=0 for 5 cycles mid-UDP packet -> s_tready=0 for those cycles, no beat lost or duplicated.
REQ-035 UDP packet ending with s_tuser=1 -> cnt_pkt[1]+1, cnt_err[1]+1; preload counter to max -> stays 32'hFFFFFFFF.
REQ-036 Assert i_rst_n low in PAYLOAD -> m_tvalid=0 immediately, map disabled, next matching-protocol packet dropped.
